can_tx_framer: RTL and testbench

- Downstream consumer of the DLC stage in the CAN transmit path.
- Latches a standard CAN 2.0A data/remote frame request: 11-bit ID, RTR, 4-bit DLC, 64-bit data.
- Serializes the frame one bit per bit-time strobe, in order: SOF, arbitration, control, data, CRC-15, delimiters, ACK slot, EOF, intermission.
- Drives the bit-level TX line toward the transceiver/bit-timing logic.

---
 rtl/can_pkg.sv | 49 ++++
 rtl/can_crc15.sv | 26 ++
 rtl/can_tx_framer.sv | 168 ++++++++++++++++
 tb/tb_can_tx_framer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN 2.0A transmit framer.
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } state_t;

    localparam logic [14:0] CRC15_POLY     = 15'h4599;
    localparam int          ID_W           = 11;
    localparam int          DLC_W          = 4;
    localparam int          CRC_W          = 15;
    localparam int          MAX_DATA_BYTES = 8;

    // Remote frames carry no payload; DLC codes above 8 still mean 8 bytes.
    function automatic logic [3:0] eff_len_f(input logic rtr, input logic [DLC_W-1:0] dlc);
        if (rtr)
            return 4'd0;
        else if (dlc > 4'(MAX_DATA_BYTES))
            return 4'(MAX_DATA_BYTES);
        else
            return dlc;
    endfunction

    function automatic state_t next_field(input state_t s, input logic no_data);
        case (s)
            ST_SOF:     return ST_ARB;
            ST_ARB:     return ST_CTRL;
            ST_CTRL:    return no_data ? ST_CRC : ST_DATA;
            ST_DATA:    return ST_CRC;
            ST_CRC:     return ST_CRC_DEL;
            ST_CRC_DEL: return ST_ACK;
            ST_ACK:     return ST_ACK_DEL;
            ST_ACK_DEL: return ST_EOF;
            ST_EOF:     return ST_IFS;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CRC-15 (CAN polynomial), cleared at frame start.
module can_crc15
    import can_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic nxt;

    assign nxt = bit_in ^ crc[CRC_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (en)
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (nxt ? CRC15_POLY : '0);
    end

endmodule

// File: rtl/can_tx_framer.sv
// CAN 2.0A transmit framer: latches one frame request and serializes it, one bit per bit_en.
// Optional bit stuffing (SOF..CRC) is enabled by defining CAN_TX_BIT_STUFF_EN.
module can_tx_framer
    import can_pkg::*;
#(
    parameter int IFS_BITS = 3,
    parameter int EOF_BITS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             start,
    input  logic [ID_W-1:0]  id,
    input  logic             rtr,
    input  logic [DLC_W-1:0] dlc,
    input  logic [63:0]      data,
    output logic             tx_bit,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [7:0]       field_len;
    logic             field_last;
    logic             bit_val;
    logic             stuff_now;
    logic             accept;
    logic             crc_en;
    logic [CRC_W-1:0] crc;

    logic [ID_W-1:0]  id_q;
    logic             rtr_q;
    logic [DLC_W-1:0] dlc_q;
    logic [63:0]      data_q;
    logic [3:0]       eff_len_q;
    logic [11:0]      arb_bits;
    logic [5:0]       ctrl_bits;

    assign accept    = (state == ST_IDLE) && start;
    assign busy      = (state != ST_IDLE);
    assign arb_bits  = {id_q, rtr_q};
    assign ctrl_bits = {1'b0, 1'b0, dlc_q};

    // Frame content is held only by the latch; it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_q      <= id;
            rtr_q     <= rtr;
            dlc_q     <= dlc;
            data_q    <= data;
            eff_len_q <= eff_len_f(rtr, dlc);
        end
    end

    always_comb begin
        case (state)
            ST_SOF:   field_len = 8'd1;
            ST_ARB:   field_len = 8'd12;
            ST_CTRL:  field_len = 8'd6;
            ST_DATA:  field_len = 8'({eff_len_q, 3'b000});
            ST_CRC:   field_len = 8'(CRC_W);
            ST_EOF:   field_len = 8'(EOF_BITS);
            ST_IFS:   field_len = 8'(IFS_BITS);
            default:  field_len = 8'd1;
        endcase
    end

    assign field_last = (cnt == field_len - 8'd1);

    // cnt counts up from 0 within each field; MSB-first selection is done by index.
    always_comb begin
        case (state)
            ST_SOF:  bit_val = 1'b0;
            ST_ARB:  bit_val = arb_bits[4'd11 - cnt[3:0]];
            ST_CTRL: bit_val = ctrl_bits[3'd5 - cnt[2:0]];
            ST_DATA: bit_val = data_q[{cnt[5:3], ~cnt[2:0]}];
            ST_CRC:  bit_val = crc[4'd14 - cnt[3:0]];
            default: bit_val = 1'b1;
        endcase
    end

`ifdef CAN_TX_BIT_STUFF_EN
    logic [2:0] run;
    logic       in_zone;

    // CRC_DEL is in the zone only so a pending stuff bit after the last CRC bit goes out.
    assign in_zone   = (state == ST_SOF) || (state == ST_ARB) || (state == ST_CTRL) ||
                       (state == ST_DATA) || (state == ST_CRC) || (state == ST_CRC_DEL);
    assign stuff_now = in_zone && (run == 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            run <= 3'd0;
        else if (accept)
            run <= 3'd0;
        else if (bit_en && in_zone) begin
            if (stuff_now)
                run <= 3'd1;
            else if (state == ST_CRC_DEL)
                run <= 3'd0;
            else if (run != 3'd0 && bit_val == tx_bit)
                run <= run + 3'd1;
            else
                run <= 3'd1;
        end
    end
`else
    assign stuff_now = 1'b0;
`endif

    assign crc_en = bit_en && !stuff_now &&
                    ((state == ST_SOF) || (state == ST_ARB) ||
                     (state == ST_CTRL) || (state == ST_DATA));

    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .en     (crc_en),
        .bit_in (bit_val),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_IDLE) begin
            if (start) begin
                state_nxt = ST_SOF;
                cnt_nxt   = 8'd0;
            end
        end else if (bit_en && !stuff_now) begin
            if (field_last) begin
                state_nxt = next_field(state, eff_len_q == 4'd0);
                cnt_nxt   = 8'd0;
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end
    end

    // tx_bit holds the last transmitted bit, so a stuff bit is simply its complement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_bit <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bit_en && state != ST_IDLE) begin
                tx_bit <= stuff_now ? ~tx_bit : bit_val;
                if (state == ST_IFS && field_last && !stuff_now)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_can_tx_framer.sv
// Directed bench for can_tx_framer; frame bits are compared against a software frame model.
module tb_can_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        start;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        tx_bit;
    logic        busy;
    logic        done;

    can_tx_framer dut (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bit_en),
        .start  (start),
        .id     (id),
        .rtr    (rtr),
        .dlc    (dlc),
        .data   (data),
        .tx_bit (tx_bit),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic        got [0:511];
    int          nbits;
    int          done_cnt;
    bit          done_wide;
    logic        exp_q [$];
    logic [14:0] exp_crc;

    function automatic logic [14:0] crc_of(input logic b [$]);
        logic [14:0] c = 15'h0;
        logic        nxt;
        foreach (b[k]) begin
            nxt = b[k] ^ c[14];
            c   = {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0);
        end
        return c;
    endfunction

    // Expected on-wire bits for one frame, as emitted from SOF through the last IFS bit.
    function automatic void build(input logic [10:0] i, input logic r, input logic [3:0] d,
                                  input logic [63:0] dat);
        logic pre [$];
        int   el;
        int   run;
        logic last;
        pre = {};
        pre.push_back(1'b0);
        for (int k = 10; k >= 0; k--) pre.push_back(i[k]);
        pre.push_back(r);
        pre.push_back(1'b0);
        pre.push_back(1'b0);
        for (int k = 3; k >= 0; k--) pre.push_back(d[k]);
        el = r ? 0 : ((d > 4'd8) ? 8 : int'(d));
        for (int b = 0; b < el; b++)
            for (int k = 7; k >= 0; k--) pre.push_back(dat[8*b+k]);
        exp_crc = crc_of(pre);
        for (int k = 14; k >= 0; k--) pre.push_back(exp_crc[k]);
        exp_q = {};
`ifdef CAN_TX_BIT_STUFF_EN
        run  = 0;
        last = 1'b0;
        foreach (pre[k]) begin
            if (run == 5) begin
                exp_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
            exp_q.push_back(pre[k]);
            if (run != 0 && pre[k] == last) run++;
            else run = 1;
            last = pre[k];
        end
        if (run == 5) exp_q.push_back(~last);
`else
        run  = 0;
        last = 1'b0;
        foreach (pre[k]) exp_q.push_back(pre[k]);
`endif
        for (int k = 0; k < 13; k++) exp_q.push_back(1'b1);
    endfunction

    function automatic logic [63:0] field(input int lo, input int n);
        logic [63:0] v = 64'h0;
        for (int k = 0; k < n; k++) v = {v[62:0], got[lo+k]};
        return v;
    endfunction

    function automatic int seq_bad();
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= nbits || got[k] !== exp_q[k]) return k;
        if (nbits != exp_q.size()) return nbits;
        return -1;
    endfunction

    task automatic launch(input logic [10:0] i, input logic r, input logic [3:0] d,
                          input logic [63:0] dat);
        @(negedge clk);
        id = i; rtr = r; dlc = d; data = dat;
        start  = 1'b1;
        bit_en = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bit_en = 1'b0;
        id = ~i; rtr = ~r; dlc = ~d; data = ~dat;
    endtask

    // Records tx_bit after every bit_en until one cycle past done (or stop_at bits).
    task automatic capture(input int stop_at, input int mid_start_at, input bit chain,
                           input logic [10:0] ci, input logic [3:0] cd, input logic [63:0] cdat);
        nbits     = 0;
        done_cnt  = 0;
        done_wide = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start  = 1'b0;
            bit_en = (cyc % 3 == 0);
            if (done_cnt > 0 && chain) begin
                start = 1'b1; id = ci; rtr = 1'b0; dlc = cd; data = cdat;
            end
            if (done_cnt == 0 && mid_start_at >= 0 && nbits == mid_start_at) begin
                start = 1'b1; id = 11'h7FF; rtr = 1'b0; dlc = 4'h8; data = '1;
            end
            @(posedge clk);
            #1;
            if (done_cnt > 0) begin
                if (done) done_wide = 1'b1;
                break;
            end
            if (bit_en && nbits < 512) begin
                got[nbits] = tx_bit;
                nbits++;
            end
            if (done) done_cnt++;
            if (stop_at > 0 && nbits == stop_at) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx_bit !== 1'b1) $display("FAIL reset_tx_bit: got %b expected 1", tx_bit); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_std_frame();
        int bad;
        build(11'h555, 1'b0, 4'd0, 64'h1122334455667788);
        launch(11'h555, 1'b0, 4'd0, 64'h1122334455667788);
        checks++;
        if (tx_bit !== 1'b1 || busy !== 1'b1)
            $display("FAIL accept_no_sof: tx_bit=%b busy=%b expected tx_bit=1 busy=1", tx_bit, busy);
        else passed++;
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_std: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (nbits !== 47) $display("FAIL len_std: got %0d expected 47", nbits); else passed++;
        checks++; if (got[0] !== 1'b0) $display("FAIL sof: got %b expected 0", got[0]); else passed++;
        checks++; if (field(1, 11) !== 64'h555) $display("FAIL id_bits: got %h expected 555", field(1, 11)); else passed++;
        checks++; if (field(12, 7) !== 64'h0) $display("FAIL ctrl_bits: got %h expected 0", field(12, 7)); else passed++;
`endif
        checks++; if (done_cnt !== 1 || done_wide) $display("FAIL done_pulse: count %0d wide %b expected 1 and 0", done_cnt, done_wide); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL busy_after: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_dlc8();
        int bad;
        build(11'h1A3, 1'b0, 4'd8, 64'h0123456789ABCDEF);
        launch(11'h1A3, 1'b0, 4'd8, 64'h0123456789ABCDEF);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_dlc8: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (nbits !== 111) $display("FAIL len_dlc8: got %0d expected 111", nbits); else passed++;
`endif
    endtask

    task automatic test_dlc12();
        int bad;
        build(11'h30F, 1'b0, 4'd12, 64'hF0E1D2C3B4A59687);
        launch(11'h30F, 1'b0, 4'd12, 64'hF0E1D2C3B4A59687);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_dlc12: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (field(15, 4) !== 64'hC) $display("FAIL dlc12_field: got %h expected c", field(15, 4)); else passed++;
        checks++; if (nbits !== 111) $display("FAIL len_dlc12: got %0d expected 111", nbits); else passed++;
`endif
    endtask

    task automatic test_remote();
        int bad;
        build(11'h2C4, 1'b1, 4'd4, '1);
        launch(11'h2C4, 1'b1, 4'd4, '1);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_remote: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (got[12] !== 1'b1) $display("FAIL rtr_bit: got %b expected 1", got[12]); else passed++;
        checks++; if (field(15, 4) !== 64'h4) $display("FAIL remote_dlc: got %h expected 4", field(15, 4)); else passed++;
        checks++; if (nbits !== 47) $display("FAIL len_remote: got %0d expected 47", nbits); else passed++;
        checks++; if (field(19, 15) !== 64'(exp_crc)) $display("FAIL remote_crc: got %h expected %h", field(19, 15), exp_crc); else passed++;
`endif
    endtask

    task automatic test_payload();
        int bad;
        build(11'h0F0, 1'b0, 4'd2, 64'hDEADBEEF1234A5C3);
        launch(11'h0F0, 1'b0, 4'd2, 64'hDEADBEEF1234A5C3);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_payload: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (field(19, 16) !== 64'hC3A5) $display("FAIL payload_order: got %h expected c3a5", field(19, 16)); else passed++;
        checks++; if (field(35, 15) !== 64'(exp_crc)) $display("FAIL payload_crc: got %h expected %h", field(35, 15), exp_crc); else passed++;
        checks++; if (nbits !== 63) $display("FAIL len_payload: got %0d expected 63", nbits); else passed++;
`endif
    endtask

    task automatic test_handshake();
        int bad;
        build(11'h123, 1'b0, 4'd1, 64'h5A);
        launch(11'h123, 1'b0, 4'd1, 64'h5A);
        capture(0, 8, 1'b1, 11'h6B5, 4'd3, 64'h00000000_00C0FFEE);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_busy_start: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
        checks++; if (done_cnt !== 1 || done_wide) $display("FAIL done_width: count %0d wide %b expected 1 and 0", done_cnt, done_wide); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL start_in_done: busy %b expected 1", busy); else passed++;
        build(11'h6B5, 1'b0, 4'd3, 64'h00000000_00C0FFEE);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_chained: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int bad;
        build(11'h7E1, 1'b0, 4'd8, 64'h0);
        launch(11'h7E1, 1'b0, 4'd8, 64'h0);
        capture(30, -1, 1'b0, 11'h0, 4'h0, 64'h0);
`ifndef CAN_TX_BIT_STUFF_EN
        checks++; if (tx_bit !== 1'b0) $display("FAIL pre_reset_bit: got %b expected 0", tx_bit); else passed++;
`endif
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_bit !== 1'b1) $display("FAIL mid_reset_tx_bit: got %b expected 1", tx_bit); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
        @(negedge clk);
        rst = 1'b0;
        build(11'h2A1, 1'b0, 4'd3, 64'h0000000000B00B1E);
        launch(11'h2A1, 1'b0, 4'd3, 64'h0000000000B00B1E);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_after_reset: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
    endtask

`ifdef CAN_TX_BIT_STUFF_EN
    task automatic test_stuffing();
        int bad;
        int run;
        int worst;
        build(11'h000, 1'b0, 4'd0, 64'h0);
        launch(11'h000, 1'b0, 4'd0, 64'h0);
        capture(0, -1, 1'b0, 11'h0, 4'h0, 64'h0);
        checks++; if (field(0, 5) !== 64'h0) $display("FAIL stuff_lead: got %h expected 0", field(0, 5)); else passed++;
        checks++; if (got[5] !== 1'b1) $display("FAIL stuff_bit: got %b expected 1", got[5]); else passed++;
        checks++; if (got[6] !== 1'b0) $display("FAIL stuff_resume: got %b expected 0", got[6]); else passed++;
        checks++; if (nbits <= 47) $display("FAIL stuff_len: got %0d expected more than 47", nbits); else passed++;
        run = 0;
        worst = 0;
        for (int k = 0; k < nbits - 13; k++) begin
            run = (k > 0 && got[k] === got[k-1]) ? run + 1 : 1;
            if (run > worst) worst = run;
        end
        checks++; if (worst > 5) $display("FAIL stuff_run: longest run %0d expected at most 5", worst); else passed++;
        bad = seq_bad();
        checks++; if (bad >= 0) $display("FAIL seq_stuff: first bad bit %0d, got %0d bits expected %0d", bad, nbits, exp_q.size()); else passed++;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        start  = 1'b0;
        id     = '0;
        rtr    = 1'b0;
        dlc    = '0;
        data   = '0;
        test_reset();
        test_std_frame();
        test_dlc8();
        test_dlc12();
        test_remote();
        test_payload();
        test_handshake();
        test_reset_mid();
`ifdef CAN_TX_BIT_STUFF_EN
        test_stuffing();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
